// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART byte receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined
// Mid-bit sampling receiver with single-entry valid/ready holding register and error pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1252
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_rx_s;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_done;
    logic             r_stop_bit;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_shift_en;
    logic             w_stop_en;
    logic             w_par_bad;
    logic             w_good;
    logic             w_load;
`ifdef UART_RX_PARITY_EN
    logic             w_par_en;
    logic             r_par_bit;
    logic             r_parity_err;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_stop_en    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !r_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-period was only a glitch.
                if (r_cnt == C_HALF) begin
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == C_FULL) begin
                    w_shift_en = 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (r_cnt == C_FULL) begin
                    w_par_en     = 1'b1;
                    w_state_next = S_STOP;
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            S_STOP: begin
                // Leave at mid stop bit so the next start edge is never missed.
                if (r_cnt == C_FULL) begin
                    w_stop_en    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state || r_state == S_IDLE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else if (r_state == S_START) begin
            r_idx <= 3'd0;
        end else if (w_shift_en) begin
            r_idx   <= r_idx + 3'd1;
            r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_done     <= 1'b0;
            r_stop_bit <= 1'b1;
        end else begin
            r_done <= w_stop_en;
            if (w_stop_en) begin
                r_stop_bit <= r_rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_par_bit <= 1'b0;
        end else if (w_par_en) begin
            r_par_bit <= r_rx_s;
        end
    end

    // Even parity: data bits and parity bit together must XOR to zero.
    assign w_par_bad = r_par_bit ^ (^r_shift);
`else
    assign w_par_bad = 1'b0;
`endif

    // r_shift is stable from the last data sample until the next frame's data phase.
    assign w_good = r_done & r_stop_bit & ~w_par_bad;
    assign w_load = w_good & (~r_rx_valid | rx_ready);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= r_done & ~r_stop_bit;
            r_overrun   <= w_good & r_rx_valid & ~rx_ready;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= r_done & r_stop_bit & w_par_bad;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
// Set UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int LATENCY = (CPB * 19) / 2 + 4 + (PAR_EN ? CPB : 0);

    typedef struct packed {
        logic [7:0] d;
        logic       stop;
        logic       par_flip;
    } frame_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_fe = 0;
    int n_ov = 0;
    int n_pe = 0;
    int t_fall = 0;
    int t_rise = -1;
    logic prev_valid = 1'b0;
    logic [7:0] acc_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
            if (parity_err) n_pe++;
            if (rx_valid && !prev_valid) t_rise = cyc;
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        end
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic frame_t mk(input logic [7:0] d, input logic stop, input logic par_flip);
        frame_t f;
        f.d = d;
        f.stop = stop;
        f.par_flip = par_flip;
        return f;
    endfunction

    // 0 = good byte, 1 = framing error, 2 = parity error
    function automatic int classify(input frame_t f);
        if (!f.stop) return 1;
        if (PAR_EN && f.par_flip) return 2;
        return 0;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        t_fall = cyc;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        if (PAR_EN) begin
            rx = (^d) ^ par_flip;
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!rx_valid && w < 2 * CPB) begin
            tick(1);
            w++;
        end
    endtask

    task automatic drain();
        if (rx_valid) begin
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        tick(2);
    endtask

    task automatic run_stream(input string name, input frame_t fr[$], input logic ready);
        int fe0 = n_fe;
        int ov0 = n_ov;
        int pe0 = n_pe;
        logic mv = 1'b0;
        logic [7:0] md = 8'h00;
        int efe = 0;
        int eov = 0;
        int epe = 0;
        logic [7:0] eacc[$];
        acc_q.delete();
        rx_ready = ready;
        foreach (fr[i]) begin
            int c = classify(fr[i]);
            send_frame(fr[i].d, fr[i].stop, fr[i].par_flip);
            if (c == 1) efe++;
            else if (c == 2) epe++;
            else if (ready) eacc.push_back(fr[i].d);
            else if (!mv) begin
                mv = 1'b1;
                md = fr[i].d;
            end else eov++;
            if (!fr[i].stop) begin
                rx = 1'b1;
                tick(CPB);
            end
        end
        tick(4);
        n_checks++;
        if (n_fe - fe0 !== efe) begin
            n_errors++;
            $display("FAIL %s frame_err count: got %0d expected %0d", name, n_fe - fe0, efe);
        end
        n_checks++;
        if (n_pe - pe0 !== epe) begin
            n_errors++;
            $display("FAIL %s parity_err count: got %0d expected %0d", name, n_pe - pe0, epe);
        end
        n_checks++;
        if (n_ov - ov0 !== eov) begin
            n_errors++;
            $display("FAIL %s overrun count: got %0d expected %0d", name, n_ov - ov0, eov);
        end
        n_checks++;
        if (rx_valid !== mv) begin
            n_errors++;
            $display("FAIL %s rx_valid: got %b expected %b", name, rx_valid, mv);
        end
        if (mv) begin
            n_checks++;
            if (rx_data !== md) begin
                n_errors++;
                $display("FAIL %s held rx_data: got %02h expected %02h", name, rx_data, md);
            end
        end
        n_checks++;
        if (acc_q.size() !== eacc.size()) begin
            n_errors++;
            $display("FAIL %s delivered count: got %0d expected %0d", name, acc_q.size(), eacc.size());
        end else begin
            foreach (eacc[i]) begin
                n_checks++;
                if (acc_q[i] !== eacc[i]) begin
                    n_errors++;
                    $display("FAIL %s delivered[%0d]: got %02h expected %02h", name, i, acc_q[i], eacc[i]);
                end
            end
        end
        rx_ready = 1'b0;
        drain();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        n_checks++;
        if ({rx_data, rx_valid, frame_err, overrun, parity_err} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset outputs: got %02h %b%b%b%b expected 00 0000",
                     rx_data, rx_valid, frame_err, overrun, parity_err);
        end
        reset = 1'b1;
        tick(CPB);
        n_checks++;
        if ({rx_valid, frame_err, overrun, parity_err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL post-reset idle flags: got %b%b%b%b expected 0000",
                     rx_valid, frame_err, overrun, parity_err);
        end
    endtask

    task automatic test_good_frame();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            int fe0 = n_fe;
            int ov0 = n_ov;
            int pe0 = n_pe;
            int lat;
            rx_ready = 1'b0;
            t_rise = -1;
            send_frame(b, 1'b1, 1'b0);
            wait_valid();
            lat = t_rise - t_fall;
            n_checks++;
            if (rx_valid !== 1'b1 || lat < LATENCY - 1 || lat > LATENCY + 1) begin
                n_errors++;
                $display("FAIL good_frame latency: valid %b after %0d cycles expected %0d", rx_valid, lat, LATENCY);
            end
            n_checks++;
            if (rx_data !== b) begin
                n_errors++;
                $display("FAIL good_frame rx_data: got %02h expected %02h", rx_data, b);
            end
            n_checks++;
            if ((n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0) !== 0) begin
                n_errors++;
                $display("FAIL good_frame error pulses: got fe %0d ov %0d pe %0d expected none",
                         n_fe - fe0, n_ov - ov0, n_pe - pe0);
            end
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            n_checks++;
            if (rx_valid !== 1'b0 || rx_data !== b) begin
                n_errors++;
                $display("FAIL good_frame accept: got valid %b data %02h expected 0 %02h", rx_valid, rx_data, b);
            end
            tick(CPB);
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 4; k++) begin
            int len = (k == 0) ? 5 : int'($urandom_range(1, 6));
            int fe0 = n_fe;
            rx = 1'b0;
            tick(len);
            rx = 1'b1;
            tick(3 * CPB);
            n_checks++;
            if (rx_valid !== 1'b0 || n_fe - fe0 !== 0) begin
                n_errors++;
                $display("FAIL glitch len %0d: got valid %b fe %0d expected 0 0", len, rx_valid, n_fe - fe0);
            end
        end
    endtask

    task automatic test_frame_err();
        int fe0 = n_fe;
        int ov0 = n_ov;
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(100);
        rx = 1'b1;
        tick(CPB);
        n_checks++;
        if (n_fe - fe0 !== 1) begin
            n_errors++;
            $display("FAIL frame_err pulses: got %0d expected 1", n_fe - fe0);
        end
        n_checks++;
        if (rx_valid !== 1'b0 || n_ov - ov0 !== 0) begin
            n_errors++;
            $display("FAIL frame_err side effects: got valid %b ov %0d expected 0 0", rx_valid, n_ov - ov0);
        end
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_valid();
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            n_errors++;
            $display("FAIL frame_err recovery: got valid %b data %02h expected 1 3c", rx_valid, rx_data);
        end
        drain();
    endtask

    task automatic test_overrun();
        frame_t fq[$];
        fq.push_back(mk(8'h11, 1'b1, 1'b0));
        fq.push_back(mk(8'h22, 1'b1, 1'b0));
        run_stream("overrun_hold", fq, 1'b0);
        run_stream("overrun_ready", fq, 1'b1);
        fq.delete();
        for (int i = 0; i < 3; i++) fq.push_back(mk(8'($urandom_range(0, 255)), 1'b1, 1'b0));
        run_stream("overrun_rand_hold", fq, 1'b0);
        run_stream("overrun_rand_ready", fq, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'($urandom_range(0, 255));
        int fe0;
        int ov0;
        int pe0;
        rx_ready = 1'b0;
        send_frame(b, 1'b1, 1'b0);
        wait_valid();
        fe0 = n_fe;
        ov0 = n_ov;
        pe0 = n_pe;
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                tick(CPB * 5 + CPB / 2);
                reset = 1'b0;
                tick(1);
                reset = 1'b1;
                n_checks++;
                if ({rx_data, rx_valid, frame_err, overrun, parity_err} !== 12'h000) begin
                    n_errors++;
                    $display("FAIL reset_mid outputs: got %02h %b%b%b%b expected 00 0000",
                             rx_data, rx_valid, frame_err, overrun, parity_err);
                end
            end
        join
        tick(2 * CPB);
        n_checks++;
        if (rx_valid !== 1'b0 || (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0) !== 0) begin
            n_errors++;
            $display("FAIL reset_mid aftermath: got valid %b fe %0d ov %0d pe %0d expected all 0",
                     rx_valid, n_fe - fe0, n_ov - ov0, n_pe - pe0);
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_valid();
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            n_errors++;
            $display("FAIL reset_mid next frame: got valid %b data %02h expected 1 5a", rx_valid, rx_data);
        end
        drain();
    endtask

    task automatic test_parity();
        frame_t fq[$];
        fq.push_back(mk(8'h07, 1'b1, 1'b0));
        run_stream("parity_ok", fq, 1'b1);
        fq.delete();
        fq.push_back(mk(8'h07, 1'b1, 1'b1));
        run_stream("parity_bad", fq, 1'b0);
        fq.delete();
        fq.push_back(mk(8'h07, 1'b0, 1'b1));
        fq.push_back(mk(8'($urandom_range(0, 255)), 1'b1, 1'b1));
        fq.push_back(mk(8'($urandom_range(0, 255)), 1'b1, 1'b0));
        run_stream("parity_mix", fq, 1'b1);
    endtask

    task automatic test_random_stream();
        for (int s = 0; s < 3; s++) begin
            frame_t fq[$];
            for (int i = 0; i < 6; i++) begin
                fq.push_back(mk(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0),
                                ($urandom_range(0, 3) == 0)));
            end
            run_stream("random_stream", fq, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        tick(1);
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        if (PAR_EN) test_parity();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial byte receiver for the UART link, the consumer of the 8N1 line produced by the transmit stage. It synchronises the asynchronous `rx` line, detects and validates the start bit, and samples each bit at mid-period. It delivers bytes through a single-entry valid/ready holding register and flags framing and overrun errors. The bit period matches the transmitter: 1252 `clock` cycles per bit by default.

## Interface
- `CLKS_PER_BIT`, default 1252: `clock` cycles per serial bit. Must be ≥ 8 and even.
- `clock` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `rx` input 1: asynchronous serial line. Idles high.
- `rx_data` output 8: received byte, LSB first on the line. Held while `rx_valid`=1.
- `rx_valid` output 1: byte available. Level signal, held until accepted.
- `rx_ready` input 1: consumer accepts the byte on any cycle where `rx_valid` & `rx_ready`.
- `frame_err` output 1: 1-cycle pulse when the stop bit is sampled low.
- `overrun` output 1: 1-cycle pulse when a completed byte is dropped because the holding register is full.
- `parity_err` output 1: 1-cycle pulse on parity mismatch. Constant 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- **Synchroniser:** two flip-flops produce `rx_s`. Both reset to 1. A registered `rx_prev` tracks `rx_s` for edge detection.
- **Counters:**
  - Bit-period counter is `$clog2(CLKS_PER_BIT)` wide and clears on every state entry.
  - 3-bit data index.
  - 8-bit shift register, filled LSB first (shift right, new bit in at MSB).
- **State machine:**
  - IDLE: on `rx_prev`=1 & `rx_s`=0, go to START.
  - START: at count `CLKS_PER_BIT/2-1`, sample `rx_s`. If 0, go to DATA with index 0. If 1, it was a glitch; go to IDLE with no outputs.
  - DATA: at count `CLKS_PER_BIT-1`, sample `rx_s` into the shift register. After index 7, go to STOP (or PARITY when enabled).
  - PARITY (macro only): at count `CLKS_PER_BIT-1`, sample and compare. Go to STOP.
  - STOP: at count `CLKS_PER_BIT-1`, sample `rx_s`, then go to IDLE immediately, half a bit early, so resync fits back-to-back frames.
- **STOP sample outcome:**
  - Sample 0: pulse `frame_err`, discard the byte.
  - Sample 1 with a parity error: pulse `parity_err`, discard the byte.
  - Otherwise the byte is good.
- **Line held low (break):** IDLE only triggers on a falling edge, so a line stuck low produces no further frames until it returns high and falls again.
- **Holding register, for a good byte:**
  - If `rx_valid`=0, or `rx_ready`=1 in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Else: keep the old `rx_data`, pulse `overrun`, drop the new byte.
- **Accept:** `rx_valid` & `rx_ready` with no new byte clears `rx_valid` on the next edge. `rx_data` keeps its last value.
- **Error precedence:** `frame_err` beats `parity_err`. A bad frame never raises `overrun`.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `parity_err`=0. State is IDLE, counters are 0, synchroniser and `rx_prev` are 1.
- **Reset mid-frame:** abandons the frame with no error pulse. Takes effect at the next edge.
- **Detection latency:** falling edge at pin to START entry is 3 cycles (2 sync + edge detect).
- **Byte latency:**
  - Stop sample falls `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT` cycles after START entry.
  - `rx_valid` and the error pulses appear on the edge after the stop sample.
  - Total from pin falling edge to `rx_valid` high is `9.5·CLKS_PER_BIT + 4` cycles.
  - With parity enabled, add `CLKS_PER_BIT`.
- **Handshake:** no combinational path from `rx_ready` to any output. Throughput is one byte per frame with no bubbles.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - One even-parity bit follows the data bits; the frame is 8E1.
  - Parity is correct when the XOR of the 8 data bits and the parity bit is 0.
  - A mismatch pulses `parity_err` and discards the byte.
- `UART_RX_PARITY_EN` undefined:
  - 8N1 frame, with no PARITY state.
  - `parity_err` is tied to 0.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **Good frame:** drive 0xA5 as 8N1 with `rx_ready`=0 → `rx_valid` rises 156 cycles after the pin falling edge (±1), `rx_data`=0xA5, no error pulses. Pulse `rx_ready` → `rx_valid`=0 next cycle.
- **Glitch:** drive `rx` low for 5 cycles, then high → stays in IDLE, no `rx_valid`, no `frame_err`.
- **Framing error:** drive 0x3C with stop bit 0, then hold the line low for 100 cycles, then high → exactly one `frame_err` pulse, `rx_valid` stays 0. A following 0x3C frame is received correctly.
- **Overrun:** back-to-back 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11, one `overrun` pulse. Repeat with `rx_ready`=1 held throughout → 0x11 then 0x22 are delivered with no `overrun`.
- **Reset mid-frame:** drop `reset` for 1 cycle during data bit 4 of 0xFF → all outputs 0, no error pulse. The next frame, 0x5A, is received correctly.
- **Parity (macro defined):**
  - 0x07 with parity bit 1 → `rx_data`=0x07 and `rx_valid` rises.
  - 0x07 with parity bit 0 → one `parity_err` pulse, no `rx_valid`.
